// File: rtl/fx_mac_pkg.sv
// Shared helpers for the fixed-point MAC path: width derivation, FSM states and the
// saturating narrowing also used by the downstream format-match stage.
package fx_mac_pkg;

    localparam int SAT_CALC_W = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Sum of ACC_LEN full-precision products needs log2(ACC_LEN) guard bits.
    function automatic int acc_width(input int a_w, input int b_w, input int acc_len);
        return a_w + b_w + clog2(acc_len);
    endfunction

    localparam int ACC_W_DEFAULT = acc_width(8, 8, 4);

    function automatic logic signed [SAT_CALC_W-1:0] saturate(
        input logic signed [SAT_CALC_W-1:0] acc,
        input int                           out_w
    );
        logic signed [SAT_CALC_W-1:0] hi;
        logic signed [SAT_CALC_W-1:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (acc > hi) begin
            return hi;
        end
        if (acc < lo) begin
            return lo;
        end
        return acc;
    endfunction

endpackage

// File: rtl/fx_sat_wrap.sv
// Combinational ACC_W->OUT_W narrowing, zero latency, no flow control. FX_MAC_SAT_EN selects
// clamping (with a saturation flag) instead of plain two's-complement wrap.
module fx_sat_wrap
    import fx_mac_pkg::*;
#(
    parameter int ACC_W = 18,
    parameter int OUT_W = 17
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic        [OUT_W-1:0] result
`ifdef FX_MAC_SAT_EN
    ,
    output logic                    sat
`endif
);

`ifdef FX_MAC_SAT_EN
    logic signed [SAT_CALC_W-1:0] acc_ext;

    assign acc_ext = SAT_CALC_W'(acc);
    assign result  = OUT_W'(saturate(acc_ext, OUT_W));
    assign sat     = (saturate(acc_ext, OUT_W) != acc_ext);
`else
    assign result = acc[OUT_W-1:0];

    // Wrap mode discards the guard bits by design.
    generate
        if (ACC_W > OUT_W) begin : g_drop_hi
            logic unused_hi;
            assign unused_hi = ^acc[ACC_W-1:OUT_W];
        end
    endgenerate
`endif

endmodule

// File: rtl/fx_mac_acc.sv
// Signed MAC summing ACC_LEN products per block; result registered 1 cycle after the last accept.
// Single-entry output buffer; o_ready drops only when a block-final beat would hit a stalled buffer. FX_MAC_SAT_EN adds o_sat.
module fx_mac_acc
    import fx_mac_pkg::*;
#(
    parameter int A_W     = 8,
    parameter int B_W     = 8,
    parameter int ACC_LEN = 4,
    parameter int OUT_W   = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic [A_W-1:0]   i_data_a,
    input  logic [B_W-1:0]   i_data_b,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [OUT_W-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
`ifdef FX_MAC_SAT_EN
    ,
    output logic             o_sat
`endif
);

    localparam int PROD_W = A_W + B_W;
    localparam int ACC_W  = acc_width(A_W, B_W, ACC_LEN);
    localparam int CNT_W  = clog2(ACC_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_LEN - 1);

    state_t                    state;
    state_t                    state_nxt;
    logic        [CNT_W-1:0]   cnt;
    logic        [CNT_W-1:0]   cnt_nxt;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_nxt;
    logic signed [ACC_W-1:0]   acc_base;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [PROD_W-1:0]  product;
    logic                      last_beat;
    logic                      accept;
    logic                      load;
    logic        [OUT_W-1:0]   conv_result;
`ifdef FX_MAC_SAT_EN
    logic                      conv_sat;
`endif

    assign product  = PROD_W'($signed(i_data_a)) * PROD_W'($signed(i_data_b));
    assign prod_ext = ACC_W'(product);
    assign acc_base = (state == ACCUM) ? acc : '0;
    assign acc_sum  = acc_base + prod_ext;

    // Only a block-final beat needs the buffer, so only it can be refused.
    assign last_beat = (cnt == LAST_CNT);
    assign o_ready   = !(last_beat && o_valid && !i_ready);
    assign accept    = i_valid && o_ready;

    fx_sat_wrap #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_conv (
        .acc    (acc_sum),
        .result (conv_result)
`ifdef FX_MAC_SAT_EN
        ,
        .sat    (conv_sat)
`endif
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        load      = 1'b0;
        if (i_clear) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            acc_nxt   = '0;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    state_nxt = ACCUM;
                    cnt_nxt   = CNT_W'(1);
                    acc_nxt   = acc_sum;
                end
                ACCUM: begin
                    if (last_beat) begin
                        load      = 1'b1;
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        acc_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                        acc_nxt = acc_sum;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            acc   <= acc_nxt;
        end
    end

    // A new result may land in the same cycle the old one drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else if (load) begin
            o_valid <= 1'b1;
            o_data  <= conv_result;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

`ifdef FX_MAC_SAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_sat <= 1'b0;
        end else if (i_clear) begin
            o_sat <= 1'b0;
        end else if (load && conv_sat) begin
            o_sat <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fx_mac_acc.sv
// Scoreboard bench for fx_mac_acc: a block-sum reference model queues expected results, a monitor pops them.
module tb_fx_mac_acc;

    localparam int A_W     = 8;
    localparam int B_W     = 8;
    localparam int ACC_LEN = 4;
    localparam int OUT_W   = 17;

`ifdef FX_MAC_SAT_EN
    localparam logic [OUT_W-1:0] NEG_EXP = 17'd65535;
`else
    localparam logic [OUT_W-1:0] NEG_EXP = 17'h10000;
`endif

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b1;
    logic             i_clear  = 1'b0;
    logic             i_valid  = 1'b0;
    logic             i_ready  = 1'b1;
    logic [A_W-1:0]   i_data_a = '0;
    logic [B_W-1:0]   i_data_b = '0;
    logic             o_ready;
    logic             o_valid;
    logic [OUT_W-1:0] o_data;
`ifdef FX_MAC_SAT_EN
    logic             o_sat;
`endif

    int               n_tests = 0;
    int               n_fail  = 0;

    longint           m_sum   = 0;
    int               m_cnt   = 0;
    bit               m_valid = 1'b0;
    bit               m_sat   = 1'b0;
    logic [OUT_W-1:0] exp_q[$];

    bit               hold_chk = 1'b0;
    logic [OUT_W-1:0] held     = '0;

    always #5 clk = ~clk;

    fx_mac_acc #(
        .A_W     (A_W),
        .B_W     (B_W),
        .ACC_LEN (ACC_LEN),
        .OUT_W   (OUT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (i_clear),
        .i_data_a (i_data_a),
        .i_data_b (i_data_b),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .i_ready  (i_ready)
`ifdef FX_MAC_SAT_EN
        ,
        .o_sat    (o_sat)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Exact block sum narrowed to OUT_W: two's-complement truncation, or clamping when enabled.
    function automatic logic [OUT_W-1:0] to_out(input longint s, output bit sat);
        longint      hi;
        longint      lo;
        logic [63:0] raw;
        hi  = (longint'(1) << (OUT_W - 1)) - 1;
        lo  = -hi - 1;
        raw = s;
        sat = 1'b0;
`ifdef FX_MAC_SAT_EN
        if (s > hi) begin
            sat = 1'b1;
            raw = hi;
        end else if (s < lo) begin
            sat = 1'b1;
            raw = lo;
        end
`else
        if (s > hi || s < lo) begin
            sat = 1'b1;
        end
`endif
        return raw[OUT_W-1:0];
    endfunction

    // Reference model, evaluated mid-cycle on the inputs that the next rising edge will see.
    always @(negedge clk) begin
        bit exp_rdy;
        bit drain;
        bit sat;
        bit new_res;
        if (rst_n) begin
            exp_rdy = !((m_cnt == ACC_LEN - 1) && m_valid && !i_ready);
            check("o_ready", 64'(o_ready), 64'(exp_rdy));
            check("o_valid", 64'(o_valid), 64'(m_valid));
`ifdef FX_MAC_SAT_EN
            check("o_sat", 64'(o_sat), 64'(m_sat));
`endif
            drain   = m_valid && i_ready;
            new_res = 1'b0;
            if (i_clear) begin
                m_sum = 0;
                m_cnt = 0;
                m_sat = 1'b0;
            end else if (i_valid && exp_rdy) begin
                m_sum += longint'($signed(i_data_a)) * longint'($signed(i_data_b));
                m_cnt++;
                if (m_cnt == ACC_LEN) begin
                    exp_q.push_back(to_out(m_sum, sat));
                    if (sat) m_sat = 1'b1;
                    m_sum   = 0;
                    m_cnt   = 0;
                    new_res = 1'b1;
                end
            end
            if (new_res) m_valid = 1'b1;
            else if (drain) m_valid = 1'b0;
        end
    end

    // Monitor: compares every transferred result and checks stall stability.
    always @(negedge clk) begin
        logic [OUT_W-1:0] e;
        if (rst_n) begin
            if (hold_chk) begin
                check("hold_valid", 64'(o_valid), 64'd1);
                check("hold_data", 64'(o_data), 64'(held));
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_output: got data %0d, expected no output", o_data);
                end else begin
                    e = exp_q.pop_front();
                    check("result", 64'(o_data), 64'(e));
                end
            end
            hold_chk = o_valid && !i_ready;
            held     = o_data;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_o_valid", 64'(o_valid), 64'd0);
        check("rst_o_data", 64'(o_data), 64'd0);
        check("rst_o_ready", 64'(o_ready), 64'd1);
`ifdef FX_MAC_SAT_EN
        check("rst_o_sat", 64'(o_sat), 64'd0);
`endif
        m_sum    = 0;
        m_cnt    = 0;
        m_valid  = 1'b0;
        m_sat    = 1'b0;
        hold_chk = 1'b0;
        exp_q.delete();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int a, input int b, output int waits);
        i_data_a = A_W'(a);
        i_data_b = B_W'(b);
        i_valid  = 1'b1;
        waits    = 0;
        forever begin
            @(negedge clk);
            if (o_ready || waits >= 50) break;
            waits++;
        end
        if (!o_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: o_ready stuck at 0, expected 1");
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic send_block(input int a, input int b);
        int w;
        for (int k = 0; k < ACC_LEN; k++) send(a, b, w);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int wsum;
        int a;
        int b;

        #1;
        do_reset();

        // Largest positive block
        send_block(127, 127);
        check("max_pos_valid", 64'(o_valid), 64'd1);
        check("max_pos_data", 64'(o_data), 64'd64516);
        @(posedge clk); #1;
        check("valid_one_cycle", 64'(o_valid), 64'd0);

        // Most negative operands: sum 65536 exceeds the 17-bit range
        send_block(-128, -128);
        check("neg_ovf_data", 64'(o_data), 64'(NEG_EXP));
`ifdef FX_MAC_SAT_EN
        check("neg_ovf_sat", 64'(o_sat), 64'd1);
`endif

        // Mixed block: 15 - 14 - 10 + 16 = 7, followed by a back-to-back block
        send(3, 5, w);
        send(-2, 7, w);
        send(10, -1, w);
        send(-4, -4, w);
        check("mixed_data", 64'(o_data), 64'd7);
        wsum = 0;
        for (int k = 0; k < ACC_LEN; k++) begin
            send(1, 2, w);
            wsum += w;
        end
        check("no_bubble", 64'(wsum), 64'd0);
        @(posedge clk); #1;

        // Backpressure: first result held, final beat of next block refused until drain
        i_ready = 1'b0;
        send_block(2, 3);
        check("bp_first_data", 64'(o_data), 64'd24);
        send(1, 1, w);
        send(1, 2, w);
        send(1, 3, w);
        i_data_a = A_W'(1);
        i_data_b = B_W'(4);
        i_valid  = 1'b1;
        @(negedge clk);
        check("bp_ready_low", 64'(o_ready), 64'd0);
        check("bp_hold_data", 64'(o_data), 64'd24);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_ready_low2", 64'(o_ready), 64'd0);
        @(posedge clk); #1;
        i_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_high", 64'(o_ready), 64'd1);
        @(posedge clk); #1;
        i_valid = 1'b0;
        check("bp_second_valid", 64'(o_valid), 64'd1);
        check("bp_second_data", 64'(o_data), 64'd10);
        @(posedge clk); #1;
        check("bp_drained", 64'(o_valid), 64'd0);

        // Clear mid-block, with operands presented in the clear cycle
        send(100, 100, w);
        send(100, 100, w);
        i_data_a = A_W'(50);
        i_data_b = B_W'(50);
        i_valid  = 1'b1;
        i_clear  = 1'b1;
        @(posedge clk); #1;
        i_clear = 1'b0;
        i_valid = 1'b0;
`ifdef FX_MAC_SAT_EN
        check("clear_sat", 64'(o_sat), 64'd0);
`endif
        send_block(1, 1);
        check("clear_data", 64'(o_data), 64'd4);
        @(posedge clk); #1;

        // Reset mid-block, then reset with a stalled result
        send(9, 9, w);
        send(9, 9, w);
        do_reset();
        i_ready = 1'b0;
        send_block(3, 3);
        check("pre_reset_valid", 64'(o_valid), 64'd1);
        do_reset();
        i_ready = 1'b1;
        send_block(5, 5);
        check("post_reset_data", 64'(o_data), 64'd100);
        @(posedge clk); #1;

        // Random traffic with random backpressure and occasional clears
        repeat (400) begin
            a = int'($urandom_range(0, 255)) - 128;
            b = int'($urandom_range(0, 255)) - 128;
            if ($urandom_range(0, 4) == 0) a = -128;
            if ($urandom_range(0, 4) == 0) b = ($urandom_range(0, 1) == 0) ? -128 : 127;
            i_data_a = A_W'(a);
            i_data_b = B_W'(b);
            i_valid  = ($urandom_range(0, 9) < 8);
            i_ready  = ($urandom_range(0, 9) < 7);
            i_clear  = ($urandom_range(0, 24) == 0);
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        i_clear = 1'b0;
        i_ready = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
